// File: rtl/alu_pipe.sv
// Pipelined integer ALU: single-cycle arithmetic/logic/multiply, iterative
// restoring divider, and a one-entry result holding stage with valid/ready handshake.
module alu_pipe #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [5:0]      aluop_i,
  input  logic            flush_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] alu_result_o,
  output logic            illegal_o,
  output logic            busy_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

  localparam logic [5:0] OP_ADD   = 6'd0;
  localparam logic [5:0] OP_SLL   = 6'd1;
  localparam logic [5:0] OP_SLT   = 6'd2;
  localparam logic [5:0] OP_SLTU  = 6'd3;
  localparam logic [5:0] OP_XOR   = 6'd4;
  localparam logic [5:0] OP_SRL   = 6'd5;
  localparam logic [5:0] OP_OR    = 6'd6;
  localparam logic [5:0] OP_AND   = 6'd7;
  localparam logic [5:0] OP_SRA   = 6'd8;
  localparam logic [5:0] OP_SUB   = 6'd9;
  localparam logic [5:0] OP_MUL   = 6'd10;
  localparam logic [5:0] OP_MULHU = 6'd11;
  localparam logic [5:0] OP_DIVU  = 6'd12;
  localparam logic [5:0] OP_REMU  = 6'd13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_n_s;

  logic [XLEN-1:0]   alu_result_r;
  logic              illegal_r;
  logic [XLEN-1:0]   rem_r;
  logic [XLEN-1:0]   quo_r;
  logic [XLEN-1:0]   dvs_r;
  logic [CW-1:0]     cnt_r;
  logic              rem_sel_r;

  logic              accept_s;
  logic              is_div_s;
  logic [SHW-1:0]    shamt_s;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   res_s;
  logic              ill_s;
  logic [XLEN:0]     shifted_s;
  logic [XLEN:0]     diff_s;
  logic [XLEN-1:0]   rem_n_s;
  logic [XLEN-1:0]   quo_n_s;

  assign ready_o      = (state_r == ST_IDLE) || ((state_r == ST_HOLD) && ready_i);
  // A flush in the same cycle drops the request even though ready_o is high.
  assign accept_s     = valid_i && ready_o && !flush_i;
  assign is_div_s     = ((aluop_i == OP_DIVU) || (aluop_i == OP_REMU)) && (op2_i != '0);
  assign shamt_s      = op2_i[SHW-1:0];
  assign prod_s       = {{XLEN{1'b0}}, op1_i} * {{XLEN{1'b0}}, op2_i};
  assign valid_o      = (state_r == ST_HOLD);
  assign busy_o       = (state_r == ST_DIV);
  assign alu_result_o = alu_result_r;
  assign illegal_o    = illegal_r;

  // Single-cycle result; DIVU/REMU values here only apply to divide-by-zero.
  always_comb begin
    res_s = '0;
    ill_s = 1'b0;
    case (aluop_i)
      OP_ADD:   res_s = op1_i + op2_i;
      OP_SLL:   res_s = op1_i << shamt_s;
      OP_SLT:   res_s = {{(XLEN-1){1'b0}}, ($signed(op1_i) < $signed(op2_i))};
      OP_SLTU:  res_s = {{(XLEN-1){1'b0}}, (op1_i < op2_i)};
      OP_XOR:   res_s = op1_i ^ op2_i;
      OP_SRL:   res_s = op1_i >> shamt_s;
      OP_OR:    res_s = op1_i | op2_i;
      OP_AND:   res_s = op1_i & op2_i;
      OP_SRA:   res_s = $signed(op1_i) >>> shamt_s;
      OP_SUB:   res_s = op1_i - op2_i;
      OP_MUL:   res_s = prod_s[XLEN-1:0];
      OP_MULHU: res_s = prod_s[2*XLEN-1:XLEN];
      OP_DIVU:  res_s = '1;
      OP_REMU:  res_s = op1_i;
      default: begin
        res_s = '0;
        ill_s = 1'b1;
      end
    endcase
  end

  // One restoring-division step: shift in the next dividend bit, trial subtract.
  always_comb begin
    shifted_s = {rem_r, quo_r[XLEN-1]};
    diff_s    = shifted_s - {1'b0, dvs_r};
    if (!diff_s[XLEN]) begin
      rem_n_s = diff_s[XLEN-1:0];
      quo_n_s = {quo_r[XLEN-2:0], 1'b1};
    end else begin
      rem_n_s = shifted_s[XLEN-1:0];
      quo_n_s = {quo_r[XLEN-2:0], 1'b0};
    end
  end

  // Next-state logic; flush has priority over everything.
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_n_s = is_div_s ? ST_DIV : ST_HOLD;
        end else begin
          state_n_s = ST_IDLE;
        end
      end
      ST_DIV: begin
        if (cnt_r == CNT_LAST) begin
          state_n_s = ST_HOLD;
        end else begin
          state_n_s = ST_DIV;
        end
      end
      ST_HOLD: begin
        if (accept_s) begin
          state_n_s = is_div_s ? ST_DIV : ST_HOLD;
        end else if (ready_i) begin
          state_n_s = ST_IDLE;
        end else begin
          state_n_s = ST_HOLD;
        end
      end
      default: state_n_s = ST_IDLE;
    endcase
    if (flush_i) begin
      state_n_s = ST_IDLE;
    end else begin
      state_n_s = state_n_s;
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n_s;
    end
  end

  // Result register and divider datapath.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      alu_result_r <= '0;
      illegal_r    <= 1'b0;
      rem_r        <= '0;
      quo_r        <= '0;
      dvs_r        <= '0;
      cnt_r        <= '0;
      rem_sel_r    <= 1'b0;
    end else if (flush_i) begin
      rem_r        <= '0;
      quo_r        <= '0;
      dvs_r        <= '0;
      cnt_r        <= '0;
      rem_sel_r    <= 1'b0;
    end else if (accept_s) begin
      if (is_div_s) begin
        rem_r     <= '0;
        quo_r     <= op1_i;
        dvs_r     <= op2_i;
        cnt_r     <= '0;
        rem_sel_r <= (aluop_i == OP_REMU);
      end else begin
        alu_result_r <= res_s;
        illegal_r    <= ill_s;
      end
    end else if (state_r == ST_DIV) begin
      rem_r <= rem_n_s;
      quo_r <= quo_n_s;
      cnt_r <= cnt_r + CW'(1);
      if (cnt_r == CNT_LAST) begin
        alu_result_r <= rem_sel_r ? rem_n_s : quo_n_s;
        illegal_r    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed cases with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_alu_pipe;

  localparam int XLEN = 32;

  logic            clk_i;
  logic            rst_ni;
  logic            valid_i;
  logic            ready_o;
  logic [XLEN-1:0] op1_i;
  logic [XLEN-1:0] op2_i;
  logic [5:0]      aluop_i;
  logic            flush_i;
  logic            valid_o;
  logic            ready_i;
  logic [XLEN-1:0] alu_result_o;
  logic            illegal_o;
  logic            busy_o;

  alu_pipe #(.XLEN(XLEN)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .op1_i        (op1_i),
    .op2_i        (op2_i),
    .aluop_i      (aluop_i),
    .flush_i      (flush_i),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .alu_result_o (alu_result_o),
    .illegal_o    (illegal_o),
    .busy_o       (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  // Model: cycles left in a divide, whether a result is being offered, and its value.
  int          m_busy;
  bit          m_have;
  logic [31:0] m_res;
  bit          m_ill;
  logic [31:0] m_pend;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [32:0] ref_op(input logic [5:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] r;
    bit          ill;
    p   = {32'd0, a} * {32'd0, b};
    ill = 1'b0;
    case (op)
      6'd0:    r = a + b;
      6'd1:    r = a << b[4:0];
      6'd2:    r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'd3:    r = (a < b) ? 32'd1 : 32'd0;
      6'd4:    r = a ^ b;
      6'd5:    r = a >> b[4:0];
      6'd6:    r = a | b;
      6'd7:    r = a & b;
      6'd8:    r = $signed(a) >>> b[4:0];
      6'd9:    r = a - b;
      6'd10:   r = p[31:0];
      6'd11:   r = p[63:32];
      6'd12:   r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      6'd13:   r = (b == 32'd0) ? a : a % b;
      default: begin r = 32'd0; ill = 1'b1; end
    endcase
    return {ill, r};
  endfunction

  task automatic model_reset();
    m_busy = 0;
    m_have = 1'b0;
    m_res  = 32'd0;
    m_ill  = 1'b0;
    m_pend = 32'd0;
  endtask

  // Inputs are already driven; compare outputs, advance the model, run one clock.
  task automatic tick();
    logic [32:0] r;
    bit          m_ready;
    #1;
    m_ready = (m_busy == 0) && (!m_have || ready_i);
    check("ready_o", ready_o, m_ready);
    check("valid_o", valid_o, m_have);
    check("busy_o", busy_o, (m_busy > 0));
    check("result", alu_result_o, m_res);
    if (m_have) check("illegal_o", illegal_o, m_ill);
    if (flush_i) begin
      m_busy = 0;
      m_have = 1'b0;
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        m_have = 1'b1;
        m_res  = m_pend;
        m_ill  = 1'b0;
      end
    end else if (valid_i && m_ready) begin
      r = ref_op(aluop_i, op1_i, op2_i);
      if ((aluop_i == 6'd12 || aluop_i == 6'd13) && op2_i != 32'd0) begin
        m_busy = XLEN;
        m_pend = r[31:0];
        m_have = 1'b0;
      end else begin
        m_have = 1'b1;
        m_res  = r[31:0];
        m_ill  = r[32];
      end
    end else if (m_have && ready_i) begin
      m_have = 1'b0;
    end
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    valid_i = 1'b1;
    aluop_i = op;
    op1_i   = a;
    op2_i   = b;
    tick();
    valid_i = 1'b0;
  endtask

  initial begin
    int          n;
    logic [31:0] last_sum;
    rst_ni  = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    flush_i = 1'b0;
    aluop_i = 6'd0;
    op1_i   = 32'd0;
    op2_i   = 32'd0;
    model_reset();
    #1;
    check("rst_valid", valid_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_result", alu_result_o, 32'd0);
    check("rst_illegal", illegal_o, 1'b0);
    check("rst_ready", ready_o, 1'b1);
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;

    ready_i = 1'b1;
    issue(6'd0, 32'hFFFF_FFFF, 32'd1);
    check("add_wrap", alu_result_o, 32'd0);
    check("add_valid", valid_o, 1'b1);
    check("add_illegal", illegal_o, 1'b0);
    issue(6'd8, 32'h8000_0000, 32'h0000_0024);
    check("sra", alu_result_o, 32'hF800_0000);
    issue(6'd2, 32'hFFFF_FFFF, 32'd1);
    check("slt", alu_result_o, 32'd1);
    issue(6'd3, 32'hFFFF_FFFF, 32'd1);
    check("sltu", alu_result_o, 32'd0);
    issue(6'd20, 32'h1234_5678, 32'd9);
    check("illegal_res", alu_result_o, 32'd0);
    check("illegal_flag", illegal_o, 1'b1);
    issue(6'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("mulhu", alu_result_o, 32'hFFFF_FFFE);

    issue(6'd12, 32'd100, 32'd7);
    check("div_busy", busy_o, 1'b1);
    check("div_ready", ready_o, 1'b0);
    n = 0;
    while (!valid_o && n < 100) begin
      tick();
      n++;
    end
    check("div_latency", n, 32);
    check("divu", alu_result_o, 32'd14);
    issue(6'd13, 32'd100, 32'd7);
    n = 0;
    while (!valid_o && n < 100) begin
      tick();
      n++;
    end
    check("remu", alu_result_o, 32'd2);
    issue(6'd12, 32'd5, 32'd0);
    check("div0_valid", valid_o, 1'b1);
    check("div0", alu_result_o, 32'hFFFF_FFFF);
    issue(6'd13, 32'd5, 32'd0);
    check("rem0", alu_result_o, 32'd5);

    // Back-to-back, then stall with ready_i low.
    valid_i  = 1'b1;
    aluop_i  = 6'd0;
    last_sum = 32'd0;
    for (int i = 0; i < 4; i++) begin
      op1_i    = $urandom;
      op2_i    = i;
      last_sum = op1_i + op2_i;
      tick();
      check("b2b_valid", valid_o, 1'b1);
      check("b2b_sum", alu_result_o, last_sum);
    end
    ready_i = 1'b0;
    op1_i   = 32'd7;
    op2_i   = 32'd8;
    tick();
    tick();
    check("stall_ready", ready_o, 1'b0);
    check("stall_result", alu_result_o, last_sum);
    valid_i = 1'b0;
    ready_i = 1'b1;
    tick();
    check("drained", valid_o, 1'b0);

    // Flush in the middle of a divide, alongside a new request.
    issue(6'd12, 32'd1000, 32'd3);
    repeat (9) tick();
    flush_i = 1'b1;
    valid_i = 1'b1;
    aluop_i = 6'd0;
    op1_i   = 32'd1;
    op2_i   = 32'd2;
    tick();
    flush_i = 1'b0;
    valid_i = 1'b0;
    check("flush_busy", busy_o, 1'b0);
    check("flush_valid", valid_o, 1'b0);
    tick();
    check("flush_dropped", valid_o, 1'b0);

    // Asynchronous reset between clock edges in the middle of a divide.
    issue(6'd12, 32'hDEAD_BEEF, 32'd13);
    repeat (5) tick();
    #2;
    rst_ni = 1'b0;
    #1;
    check("arst_busy", busy_o, 1'b0);
    check("arst_valid", valid_o, 1'b0);
    check("arst_result", alu_result_o, 32'd0);
    check("arst_ready", ready_o, 1'b1);
    model_reset();
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (40) tick();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      int sel;
      valid_i = ($urandom_range(0, 3) != 0);
      ready_i = ($urandom_range(0, 3) != 0);
      flush_i = ($urandom_range(0, 63) == 0);
      sel     = $urandom_range(0, 15);
      aluop_i = (sel < 14) ? 6'(sel) : 6'($urandom_range(14, 63));
      op1_i   = $urandom;
      sel     = $urandom_range(0, 7);
      if (sel == 0) op2_i = 32'd0;
      else if (sel < 3) op2_i = $urandom_range(1, 255);
      else op2_i = $urandom;
      tick();
    end
    valid_i = 1'b0;
    flush_i = 1'b0;
    ready_i = 1'b1;
    repeat (40) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; legal values 8..64, power of two.
REQ-002 SHALL have parameter SHW, default $clog2(XLEN), number of shift-amount bits taken from op2_i.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 valid_i  input  1  request valid.
REQ-006 ready_o  output  1  block accepts a request this cycle.
REQ-007 op1_i  input  XLEN  operand 1.
REQ-008 op2_i  input  XLEN  operand 2.
REQ-009 aluop_i  input  6  opcode.
REQ-010 flush_i  input  1  cancel any in-flight or held operation.
REQ-011 valid_o  output  1  result valid.
REQ-012 ready_i  input  1  consumer accepts the result.
REQ-013 alu_result_o  output  XLEN  registered result.
REQ-014 illegal_o  output  1  qualifies valid_o; opcode was unsupported.
REQ-015 busy_o  output  1  iterative divide in progress.

Function
REQ-016 Acceptance SHALL occur when valid_i && ready_o at the clock edge; inputs sampled only then.
REQ-017 Opcodes SHALL be: 0 ADD, 1 SLL, 2 SLT (signed), 3 SLTU, 4 XOR, 5 SRL, 6 OR, 7 AND, 8 SRA, 9 SUB, 10 MUL (low XLEN bits), 11 MULHU (high XLEN bits, unsigned), 12 DIVU, 13 REMU.
REQ-018 Shifts SHALL use op2_i[SHW-1:0] only; upper bits ignored.
REQ-019 SLT/SLTU SHALL produce 1 or 0 zero-extended to XLEN.
REQ-020 ADD/SUB/MUL SHALL wrap modulo 2^XLEN; no overflow flag.
REQ-021 FSM states SHALL be IDLE (no result held), DIV (iterating), HOLD (valid_o=1, awaiting ready_i).
REQ-022 Opcodes 0-11, 14-63, and 12/13 with op2_i==0 SHALL go IDLE/HOLD -> HOLD with result registered; latency 1 cycle acceptance-to-valid_o.
REQ-023 DIVU/REMU with op2_i!=0 SHALL enter DIV, run restoring division one quotient bit per cycle for exactly XLEN cycles, then enter HOLD; latency XLEN+1 cycles.
REQ-024 Divide by zero SHALL return all-ones for DIVU and op1_i for REMU, 1-cycle latency.
REQ-025 Opcodes 14-63 SHALL return result 0 with illegal_o=1; illegal_o=0 for all legal opcodes.
REQ-026 ready_o SHALL equal (state==IDLE) || (state==HOLD && ready_i) and SHALL be 0 in DIV; ready_o SHALL NOT depend on valid_i.
REQ-027 In HOLD, alu_result_o and illegal_o SHALL remain stable until valid_o && ready_i.
REQ-028 HOLD with ready_i=1 and no new acceptance SHALL go to IDLE, valid_o=0 next cycle.
REQ-029 HOLD with ready_i=1 and simultaneous acceptance SHALL load the new result (or enter DIV) with no bubble for 1-cycle ops.
REQ-030 busy_o SHALL be 1 exactly while state==DIV.
REQ-031 flush_i=1 SHALL force next state IDLE, valid_o=0, busy_o=0, discard divider state; flush SHALL override a same-cycle acceptance (request dropped).
REQ-032 When state==IDLE, alu_result_o SHALL retain its last value (not cleared).

Reset
REQ-033 rst_ni=0 SHALL immediately force state IDLE, valid_o=0, illegal_o=0, busy_o=0, alu_result_o=0, divider registers 0, independent of clk_i.
REQ-034 ready_o SHALL be 1 during and after reset while ready_i is irrelevant (IDLE).
REQ-035 Reset asserted mid-DIV or mid-HOLD SHALL abandon the operation; no result delivered after deassertion.

Verification
REQ-036 XLEN=32, ADD 0xFFFFFFFF+1, ready_i=1 -> valid_o next cycle, result 0x00000000, illegal_o=0.
REQ-037 SRA op1=0x80000000, op2=0x00000024 -> shift 4, result 0xF8000000; SLT 0xFFFFFFFF vs 1 -> 1; SLTU same -> 0.
REQ-038 DIVU 100/7 -> busy_o high 32 cycles, ready_o=0, valid_o at cycle 33, result 14; REMU 100/7 -> 2; DIVU 5/0 -> 0xFFFFFFFF at cycle 1.
REQ-039 Back-to-back ADDs with ready_i=1 -> one result per cycle; ready_i=0 two cycles -> result stable, ready_o=0, then drains on ready_i=1.
REQ-040 flush_i at DIV cycle 10 with valid_i=1 -> busy_o=0 and valid_o=0 next cycle, new request not accepted; opcode 20 -> result 0, illegal_o=1.
REQ-041 rst_ni low mid-DIV between clock edges -> outputs zero immediately, no valid_o after release.
